// File: rtl/mem_arbiter_rr_if.sv
// Requester/RAM bundle shared between the arbiter and the outside world.
// Latency: none, wires only.
// Backpressure: carried by gnt/stall; requesters hold req until granted.
interface mem_arbiter_rr_if #(
    parameter int NUM_PORTS = 2
);
    // Requester side
    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    lock;
    logic [NUM_PORTS*32-1:0] addr;
    logic [NUM_PORTS*4-1:0]  we;
    logic [NUM_PORTS*32-1:0] wdata;
    logic [NUM_PORTS-1:0]    gnt;
    logic [NUM_PORTS-1:0]    stall;
    logic [NUM_PORTS-1:0]    rvalid;
    logic [31:0]             rdata;

    // RAM side
    logic                    ram_en;
    logic [31:0]             ram_addr;
    logic [3:0]              ram_we;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;

    // The master view is everything outside the arbiter: requesters plus the RAM.
    modport master (
        output req, lock, addr, we, wdata, ram_rdata,
        input  gnt, stall, rvalid, rdata, ram_en, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  req, lock, addr, we, wdata, ram_rdata,
        output gnt, stall, rvalid, rdata, ram_en, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Arbitrates NUM_PORTS requesters onto one synchronous RAM port with segment address translation.
// Latency: grant and RAM drive combinational in the request cycle; read data returned on rvalid one cycle later.
// Backpressure: ungranted requesters see stall and hold req; a locked owner blocks every other port.
module mem_arbiter_rr #(
    parameter int          NUM_PORTS    = 2,
    parameter int          PRIO_MODE    = 0,
    parameter logic [15:0] SEG_TEXT_HI  = 16'h0040,
    parameter logic [15:0] SEG_DATA_HI  = 16'h1001,
    parameter logic [15:0] SEG_STACK_HI = 16'h7FFF
) (
    input logic             clk,
    input logic             rst_n,
    mem_arbiter_rr_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     last_gnt;
    logic [NUM_PORTS-1:0] rvalid_q;
    logic [31:0]          addr_hold;

    logic [NUM_PORTS-1:0] req_rot;
    logic [CNT_W-1:0]     rr_start;
    logic [CNT_W-1:0]     rr_off;
    logic [CNT_W-1:0]     rr_sum;
    logic                 rr_hit;
    logic [IDX_W-1:0]     rr_idx;
    logic                 fp_hit;
    logic [IDX_W-1:0]     fp_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic                 granted;
    logic [NUM_PORTS-1:0] gnt_vec;

    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_we;
    logic [1:0]           seg;
    logic [31:0]          xlat_addr;

    // Round-robin candidate: rotate requests so the port after last_gnt lands on bit 0.
    always_comb begin
        rr_start = {1'b0, last_gnt} + CNT_W'(1);
        req_rot  = NUM_PORTS'({bus.req, bus.req} >> rr_start);
        rr_hit   = 1'b0;
        rr_off   = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                rr_hit = 1'b1;
                rr_off = CNT_W'(j);
            end
        end
        rr_sum = rr_start + rr_off;
        if (rr_sum >= CNT_W'(NUM_PORTS)) begin
            rr_sum = rr_sum - CNT_W'(NUM_PORTS);
        end
        rr_idx = IDX_W'(rr_sum);
    end

    // Winner selection: the lock owner if locked, else fixed priority or round-robin.
    always_comb begin
        fp_hit = 1'b0;
        fp_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                fp_hit = 1'b1;
                fp_idx = IDX_W'(i);
            end
        end

        if (state == LOCKED) begin
            pick_any = bus.req[owner];
            pick_idx = owner;
        end else if (PRIO_MODE != 0) begin
            pick_any = fp_hit;
            pick_idx = fp_idx;
        end else begin
            pick_any = rr_hit;
            pick_idx = rr_idx;
        end

        // Reset masks the grant at once, without waiting for an edge.
        granted = rst_n & pick_any;
        gnt_vec = granted ? (NUM_PORTS'(1) << pick_idx) : '0;
    end

    // Route the granted port onto the RAM bus and translate its address into a segment.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_vec[i]) begin
                sel_addr  = bus.addr[32*i +: 32];
                sel_wdata = bus.wdata[32*i +: 32];
                sel_we    = bus.we[4*i +: 4];
            end
        end

        if (sel_addr[31:16] >= SEG_STACK_HI) begin
            seg = 2'd2;
        end else if (sel_addr[31:16] >= SEG_DATA_HI) begin
            seg = 2'd1;
        end else if (sel_addr[31:16] >= SEG_TEXT_HI) begin
            seg = 2'd0;
        end else begin
            seg = 2'd3;
        end

        // Byte offset is dropped silently; the RAM is word addressed.
        xlat_addr = {14'd0, seg, sel_addr[15:0] & 16'hFFFC};
    end

    // Arbitration FSM: lock ownership and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            owner    <= '0;
            last_gnt <= IDX_W'(NUM_PORTS - 1);
        end else begin
            if (granted) begin
                last_gnt <= pick_idx;
            end
            case (state)
                ARB: begin
                    if (granted && bus.lock[pick_idx]) begin
                        state <= LOCKED;
                        owner <= pick_idx;
                    end
                end
                LOCKED: begin
                    // The owner keeps the bus even while idle, until it drops lock.
                    if (!bus.lock[owner]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Read-return pulse for the port read last cycle, and the idle-cycle RAM address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q  <= '0;
            addr_hold <= '0;
        end else begin
            rvalid_q <= (granted && (sel_we == 4'h0)) ? gnt_vec : '0;
            if (granted) begin
                addr_hold <= xlat_addr;
            end
        end
    end

    assign bus.gnt       = gnt_vec;
    assign bus.stall     = bus.req & ~gnt_vec;
    assign bus.rvalid    = rvalid_q;
    // RAM data is shared by all ports; blank it when nobody is being answered.
    assign bus.rdata     = (|rvalid_q) ? bus.ram_rdata : 32'h0;
    assign bus.ram_en    = granted;
    assign bus.ram_addr  = granted ? xlat_addr : addr_hold;
    assign bus.ram_we    = granted ? sel_we : 4'h0;
    assign bus.ram_wdata = granted ? sel_wdata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: two instances (round-robin and fixed priority) on a shared stimulus.
// Latency: model predicts grants in-cycle and read returns one cycle later.
// Backpressure: requesters hold req while stalled, as the directed vectors do.
module tb_mem_arbiter_rr;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_rr_if #(.NUM_PORTS(NP)) bus ();
    mem_arbiter_rr_if #(.NUM_PORTS(NP)) bus_fp ();

    mem_arbiter_rr #(.NUM_PORTS(NP), .PRIO_MODE(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_arbiter_rr #(.NUM_PORTS(NP), .PRIO_MODE(1)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp)
    );

    assign bus_fp.req       = bus.req;
    assign bus_fp.lock      = bus.lock;
    assign bus_fp.addr      = bus.addr;
    assign bus_fp.we        = bus.we;
    assign bus_fp.wdata     = bus.wdata;
    assign bus_fp.ram_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return wa ^ 32'hA5A5_0000;
    endfunction

    // Synchronous RAM attached to the round-robin instance.
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ram_cur;
    always @(posedge clk) begin
        if (bus.ram_en === 1'b1) begin
            ram_cur = ram_mem.exists(bus.ram_addr) ? ram_mem[bus.ram_addr] : init_word(bus.ram_addr);
            bus.ram_rdata <= ram_cur;
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_we[b]) ram_cur[8*b +: 8] = bus.ram_wdata[8*b +: 8];
            end
            ram_mem[bus.ram_addr] = ram_cur;
        end
    end

    // ---------------- behavioural model ----------------
    int          m_locked [2] = '{0, 0};
    int          m_owner  [2] = '{0, 0};
    int          m_last   [2] = '{NP - 1, NP - 1};
    int          pend = -1;
    logic [31:0] pend_data = '0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_mem [logic [31:0]];

    function automatic bit req_on(input int p);
        return (p == 0) ? bus.req[0] : bus.req[1];
    endfunction
    function automatic bit lock_on(input int p);
        return (p == 0) ? bus.lock[0] : bus.lock[1];
    endfunction
    function automatic logic [31:0] p_addr(input int p);
        return (p == 0) ? bus.addr[31:0] : bus.addr[63:32];
    endfunction
    function automatic logic [3:0] p_we(input int p);
        return (p == 0) ? bus.we[3:0] : bus.we[7:4];
    endfunction
    function automatic logic [31:0] p_wdata(input int p);
        return (p == 0) ? bus.wdata[31:0] : bus.wdata[63:32];
    endfunction

    function automatic logic [1:0] onehot(input int p);
        logic [1:0] one;
        one = 2'b01;
        return (p < 0) ? 2'b00 : (one << p);
    endfunction

    function automatic logic [31:0] m_xlat(input logic [31:0] a);
        int hi;
        int seg;
        hi = int'(a >> 16);
        if (hi >= 'h7FFF)      seg = 2;
        else if (hi >= 'h1001) seg = 1;
        else if (hi >= 'h0040) seg = 0;
        else                   seg = 3;
        return 32'(seg * 65536) + (a % 65536) - (a % 4);
    endfunction

    // k=0: round-robin instance, k=1: fixed-priority instance.
    function automatic int model_pick(input int k);
        if (m_locked[k] != 0) return req_on(m_owner[k]) ? m_owner[k] : -1;
        if (k == 1) begin
            for (int i = 0; i < NP; i++) if (req_on(i)) return i;
            return -1;
        end
        for (int s = 1; s <= NP; s++) begin
            if (req_on((m_last[k] + s) % NP)) return (m_last[k] + s) % NP;
        end
        return -1;
    endfunction

    int          p_rr, p_fp, p_cur;
    logic [31:0] e_addr, e_rdata, e_wdata, m_word;
    logic [1:0]  e_rv;
    logic [3:0]  e_we;

    // Per-cycle compare of both instances against the model, then model advance.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            p_rr = -1; p_fp = -1; pend = -1; m_hold = '0;
        end else begin
            p_rr = model_pick(0);
            p_fp = model_pick(1);
        end
        e_rv    = onehot(pend);
        e_rdata = (pend >= 0) ? pend_data : 32'h0;
        e_addr  = (p_rr >= 0) ? m_xlat(p_addr(p_rr)) : m_hold;
        e_we    = (p_rr >= 0) ? p_we(p_rr) : 4'h0;
        e_wdata = (p_rr >= 0) ? p_wdata(p_rr) : 32'h0;

        chk("gnt",       32'(bus.gnt),       32'(onehot(p_rr)));
        chk("stall",     32'(bus.stall),     32'(bus.req & ~onehot(p_rr)));
        chk("rvalid",    32'(bus.rvalid),    32'(e_rv));
        chk("rdata",     bus.rdata,          e_rdata);
        chk("ram_en",    32'(bus.ram_en),    32'(p_rr >= 0));
        chk("ram_addr",  bus.ram_addr,       e_addr);
        chk("ram_we",    32'(bus.ram_we),    32'(e_we));
        chk("ram_wdata", bus.ram_wdata,      e_wdata);
        chk("fp_gnt",    32'(bus_fp.gnt),    32'(onehot(p_fp)));
        chk("fp_stall",  32'(bus_fp.stall),  32'(bus.req & ~onehot(p_fp)));

        if (rst_n !== 1'b1) begin
            m_locked = '{0, 0};
            m_last   = '{NP - 1, NP - 1};
        end else begin
            for (int k = 0; k < 2; k++) begin
                p_cur = (k == 0) ? p_rr : p_fp;
                if (m_locked[k] != 0) begin
                    if (!lock_on(m_owner[k])) m_locked[k] = 0;
                end else if (p_cur >= 0 && lock_on(p_cur)) begin
                    m_locked[k] = 1;
                    m_owner[k]  = p_cur;
                end
                if (p_cur >= 0) m_last[k] = p_cur;
            end
            pend = -1;
            if (p_rr >= 0) begin
                m_hold = e_addr;
                m_word = m_mem.exists(e_addr) ? m_mem[e_addr] : init_word(e_addr);
                if (e_we == 4'h0) begin
                    pend      = p_rr;
                    pend_data = m_word;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (e_we[b]) m_word[8*b +: 8] = e_wdata[8*b +: 8];
                    end
                    m_mem[e_addr] = m_word;
                end
            end
        end
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] l,
                         input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        bus.req   = r;
        bus.lock  = l;
        bus.addr  = {a1, a0};
        bus.we    = {w1, w0};
        bus.wdata = {d1, d0};
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [1:0] seq [4];

    initial begin
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst_n     = 1'b1;
        bus.req   = 2'b11;
        bus.lock  = 2'b00;
        bus.addr  = {32'h1001_0020, 32'h0040_0010};
        bus.we    = '0;
        bus.wdata = '0;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_gnt",      32'(bus.gnt),    32'h0);
        chk("rst_stall",    32'(bus.stall),  32'h3);
        chk("rst_rvalid",   32'(bus.rvalid), 32'h0);
        chk("rst_ram_addr", bus.ram_addr,    32'h0);

        // Alternating grants with both ports reading.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2 chk("rr_gnt0", 32'(bus.gnt), 32'(seq[0]));
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #3;
            chk("rr_gnt",    32'(bus.gnt),    32'(seq[i]));
            chk("rr_rvalid", 32'(bus.rvalid), 32'(seq[i-1]));
        end
        drive(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("rr_rvalid_last", 32'(bus.rvalid), 32'h2);
        chk("rr_rdata_init",  bus.rdata,       32'hA5A4_0020);
        chk("idle_ram_en",    32'(bus.ram_en), 32'h0);
        chk("idle_hold_addr", bus.ram_addr,    32'h0001_0020);

        // Write by port 1, read back by port 0, then read followed by write.
        drive(2'b10, 2'b00, 32'h0, 4'h0, 32'h0, 32'h1001_0008, 4'hF, 32'hDEAD_BEEF);
        chk("wr_addr",  bus.ram_addr,         32'h0001_0008);
        chk("wr_we",    32'(bus.ram_we),      32'hF);
        chk("wr_wdata", bus.ram_wdata,        32'hDEAD_BEEF);
        drive(2'b01, 2'b00, 32'h1001_0008, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("rd_addr",      bus.ram_addr,     32'h0001_0008);
        chk("wr_no_rvalid", 32'(bus.rvalid),  32'h0);
        drive(2'b10, 2'b00, 32'h0, 4'h0, 32'h0, 32'h1001_0008, 4'hF, 32'h1234_5678);
        chk("rd_rvalid", 32'(bus.rvalid), 32'h1);
        chk("rd_rdata",  bus.rdata,       32'hDEAD_BEEF);
        drive(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("rdata_zero", bus.rdata, 32'h0);

        // Segment translation sweep and a partial-byte write.
        drive(2'b01, 2'b00, 32'h7FFF_EFFC, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("xlat_stack", bus.ram_addr, 32'h0002_EFFC);
        drive(2'b01, 2'b00, 32'h0040_0004, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("xlat_text", bus.ram_addr, 32'h0000_0004);
        drive(2'b01, 2'b00, 32'h0000_1006, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("xlat_low", bus.ram_addr, 32'h0003_1004);
        drive(2'b10, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0040_0004, 4'h3, 32'h1111_2222);
        drive(2'b01, 2'b00, 32'h0040_0006, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        drive(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        chk("byte_merge", bus.rdata, 32'hA5A5_2222);

        // Lock: port 0 owns the bus for three grants while port 1 waits.
        drive(2'b10, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0040_0100, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b01, 32'h1001_0010, 4'h0, 32'h0, 32'h0040_0100, 4'h0, 32'h0);
            chk("lock_gnt",   32'(bus.gnt),   32'h1);
            chk("lock_stall", 32'(bus.stall), 32'h2);
        end
        drive(2'b10, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0040_0100, 4'h0, 32'h0);
        chk("lock_idle_gnt",   32'(bus.gnt),   32'h0);
        chk("lock_idle_stall", 32'(bus.stall), 32'h2);
        drive(2'b10, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0040_0100, 4'h0, 32'h0);
        chk("unlock_gnt", 32'(bus.gnt), 32'h2);

        // Fixed priority: port 0 always wins.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b00, 32'h0040_0200, 4'h0, 32'h0, 32'h0040_0300, 4'h0, 32'h0);
            chk("fp_gnt_lit",   32'(bus_fp.gnt),   32'h1);
            chk("fp_stall_lit", 32'(bus_fp.stall), 32'h2);
        end

        // Reset during a locked, pending read.
        drive(2'b01, 2'b01, 32'h0040_0400, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        drive(2'b11, 2'b01, 32'h0040_0400, 4'h0, 32'h0, 32'h0040_0500, 4'h0, 32'h0);
        #3 rst_n = 1'b0;
        #2;
        chk("mid_rst_gnt",    32'(bus.gnt),    32'h0);
        chk("mid_rst_stall",  32'(bus.stall),  32'h3);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("mid_rst_addr",   bus.ram_addr,    32'h0);
        @(posedge clk);
        #1 chk("rst_no_rvalid", 32'(bus.rvalid), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus.lock = 2'b00;
        #2 chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
        @(posedge clk);
        #3 chk("post_rst_rvalid", 32'(bus.rvalid), 32'h1);
        drive(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);
        drive(2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
